// File: rtl/rx_band_pass_fir_mac_pkg.sv
// Shared constants, FSM encoding and output saturation for the RX band-pass FIR engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rx_band_pass_fir_mac_pkg;

    localparam int TAPS      = 512;
    localparam int AW        = $clog2(TAPS);
    localparam int DATA_W    = 16;
    localparam int PROD_W    = 2 * DATA_W;
    localparam int ACC_W     = PROD_W + AW;
    localparam int OUT_SHIFT = 10;

    // Pipeline flush after the last tap: BRAM read, product register, accumulate.
    localparam int DRAIN_CYCLES = 3;

    // Saturation limits, in output width and sign-extended to accumulator width.
    localparam logic signed [DATA_W-1:0] SAT_MAX     = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN     = 16'sh8000;
    localparam logic signed [ACC_W-1:0]  SAT_MAX_ACC = {{(ACC_W-DATA_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0]  SAT_MIN_ACC = {{(ACC_W-DATA_W){1'b1}}, SAT_MIN};

    // FSM encoding.
    localparam logic [2:0] ST_CLEAR  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_MAC    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;

    // Arithmetic shift down by OUT_SHIFT, then clamp to the signed 16-bit range.
    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > SAT_MAX_ACC) begin
            return SAT_MAX;
        end else if (s < SAT_MIN_ACC) begin
            return SAT_MIN;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/rx_band_pass_fir_mac_history_ram.sv
// Sample history store: simple dual-port RAM, one synchronous write and one registered read port.
// Latency: read data valid 1 cycle after raddr; write takes effect at the clock edge.
// Backpressure: none; always accepts a write and a read every cycle.
module rx_fir_history_ram
    import rx_band_pass_fir_mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [DATA_W-1:0] rdout
);

    logic signed [DATA_W-1:0] mem [TAPS];
    logic signed [DATA_W-1:0] rdout_q;

    // Array and read register carry no reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdout_q <= mem[raddr];
    end

    assign rdout = rdout_q;

endmodule

// File: rtl/rx_band_pass_fir_mac.sv
// Time-multiplexed 512-tap band-pass FIR, one MAC per clock; optional rounding via RX_FIR_ROUND_EN.
// Latency: 516 cycles from accept to fir_out_valid; one sample in flight at a time.
// Backpressure: sample_ready low while busy; a sample offered then is dropped and overrun pulses.
module rx_band_pass_fir_mac
    import rx_band_pass_fir_mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     rrx_rst,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     coef_en,
    output logic [AW-1:0]            coef_addr,
    input  logic signed [DATA_W-1:0] coef_data,
    output logic signed [DATA_W-1:0] fir_out,
    output logic                     fir_out_valid,
    output logic                     overrun
);

    logic [2:0]               state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;      // CLEAR address / DRAIN cycle count
    logic [AW-1:0]            k_q, k_d;          // tap index during MAC
    logic [AW-1:0]            wp_q, wp_d;        // history slot of the newest sample
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] prod_d;
    logic                     rd_vld_q;          // coef_data / history data valid this cycle
    logic                     prod_vld_q;        // prod_q holds a tap product this cycle
    logic signed [DATA_W-1:0] fir_out_q;
    logic signed [ACC_W-1:0]  acc_rnd;

    logic                     accept;
    logic                     hist_we;
    logic [AW-1:0]            hist_waddr;
    logic signed [DATA_W-1:0] hist_wdata;
    logic [AW-1:0]            hist_raddr;
    logic signed [DATA_W-1:0] hist_rdata;

    assign sample_ready  = (state_q == ST_IDLE) || (state_q == ST_OUTPUT);
    assign accept        = sample_valid && sample_ready;
    // Overrun is forced low while reset is held so outputs sit at their reset values.
    assign overrun       = sample_valid && !sample_ready && !rrx_rst;
    assign coef_en       = (state_q == ST_MAC);
    assign coef_addr     = k_q;
    assign fir_out_valid = (state_q == ST_OUTPUT);
    assign fir_out       = fir_out_q;

    // History write port: zero-fill while clearing, otherwise store the accepted sample.
    always_comb begin
        hist_we    = 1'b0;
        hist_waddr = wp_q;
        hist_wdata = sample_in;
        if (state_q == ST_CLEAR) begin
            hist_we    = 1'b1;
            hist_waddr = cnt_q;
            hist_wdata = '0;
        end else if (accept) begin
            hist_we = 1'b1;
        end
    end

    // x[n-k] lives k slots behind the newest sample, wrapping modulo TAPS.
    assign hist_raddr = wp_q - k_q;

    rx_fir_history_ram u_hist (
        .clk   (clk),
        .we    (hist_we),
        .waddr (hist_waddr),
        .wdata (hist_wdata),
        .raddr (hist_raddr),
        .rdout (hist_rdata)
    );

    // Next-state logic for the control FSM and its counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        wp_d    = wp_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(TAPS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_OUTPUT: begin
                if (accept) begin
                    state_d = ST_MAC;
                    k_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                // k wraps back to 0 after the last tap, leaving coef_addr at 0 outside MAC.
                k_d = k_q + 1'b1;
                if (k_q == AW'(TAPS - 1)) begin
                    state_d = ST_DRAIN;
                    wp_d    = wp_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_OUTPUT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            k_q     <= '0;
            wp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            wp_q    <= wp_d;
        end
    end

    // Full-precision signed product of the coefficient and history words.
    assign prod_d = PROD_W'(coef_data) * PROD_W'(hist_rdata);

    // MAC pipeline: read-valid tag, product register, accumulator.
    always_ff @(posedge clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            rd_vld_q   <= 1'b0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
        end else begin
            rd_vld_q   <= coef_en;
            prod_vld_q <= rd_vld_q;
            if (rd_vld_q) begin
                prod_q <= prod_d;
            end
            if (accept) begin
                acc_q <= '0;
            end else if (prod_vld_q) begin
                acc_q <= acc_q + ACC_W'(prod_q);
            end
        end
    end

`ifdef RX_FIR_ROUND_EN
    // Round half up: bias by half an output LSB before the arithmetic shift.
    assign acc_rnd = acc_q + (ACC_W'(1) <<< (OUT_SHIFT - 1));
`else
    assign acc_rnd = acc_q;
`endif

    // Output register loads on the last drain cycle and holds until the next result.
    always_ff @(posedge clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            fir_out_q <= '0;
        end else if ((state_q == ST_DRAIN) && (cnt_q == AW'(DRAIN_CYCLES - 1))) begin
            fir_out_q <= sat_out(acc_rnd);
        end
    end

endmodule
